// File: rtl/snax_alu_csr_ctrl.sv
// CSR/control block for the SNAX ALU: active + one-deep shadow config, lane-based
// completion tracking, read-only status/perf/job CSRs and a done pulse on retirement.
module snax_alu_csr_ctrl #(
    parameter int RegRWCount   = 4,
    parameter int RegROCount   = 3,
    parameter int RegDataWidth = 32,
    parameter int NumLanes     = 4,
    parameter int AluCfgWidth  = 2
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic [RegRWCount*RegDataWidth-1:0] csr_reg_set_i,
    input  logic                               csr_reg_set_valid_i,
    output logic                               csr_reg_set_ready_o,
    output logic [RegROCount*RegDataWidth-1:0] csr_reg_ro_set_o,
    output logic [RegRWCount*RegDataWidth-1:0] csr_reg_active_o,
    input  logic [NumLanes-1:0]                acc_output_success_i,
    output logic                               acc_ready_o,
    output logic [AluCfgWidth-1:0]             csr_alu_config_o,
    output logic                               done_o
);

    localparam int IncW = $clog2(NumLanes + 1);
    localparam int SumW = RegDataWidth + 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                             state;
    logic [RegRWCount*RegDataWidth-1:0] active;
    logic [RegRWCount*RegDataWidth-1:0] shadow;
    logic                               shadow_valid;
    logic [RegDataWidth-1:0]            elem_cnt;
    logic [RegDataWidth-1:0]            perf;
    logic [RegDataWidth-1:0]            jobs;
    logic                               done;

    logic                               busy;
    logic                               accept;
    logic                               finish;
    logic [IncW-1:0]                    inc;
    logic [RegDataWidth-1:0]            len;
    logic [SumW-1:0]                    sum;

    // Handshake: a config set transfers on a cycle where valid and ready are both high;
    // ready only depends on shadow occupancy, so it never waits on valid.
    assign busy   = (state == BUSY);
    assign accept = csr_reg_set_valid_i && csr_reg_set_ready_o;
    assign len    = active[RegDataWidth +: RegDataWidth];

    always_comb begin
        inc = '0;
        for (int i = 0; i < NumLanes; i++) begin
            inc = inc + IncW'(acc_output_success_i[i]);
        end
    end

    // Extra bit on the sum keeps the >= compare correct when elem_cnt is near the top.
    assign sum    = {1'b0, elem_cnt} + SumW'(inc);
    assign finish = busy && (sum >= {1'b0, len});

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= IDLE;
            active       <= '0;
            shadow       <= '0;
            shadow_valid <= 1'b0;
            elem_cnt     <= '0;
            perf         <= '0;
            jobs         <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        active   <= csr_reg_set_i;
                        elem_cnt <= '0;
                        perf     <= RegDataWidth'(1);
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        done     <= 1'b1;
                        jobs     <= jobs + 1'b1;
                        elem_cnt <= '0;
                        if (shadow_valid) begin
                            active       <= shadow;
                            shadow_valid <= 1'b0;
                            perf         <= RegDataWidth'(1);
                        end else if (accept) begin
                            active <= csr_reg_set_i;
                            perf   <= RegDataWidth'(1);
                        end else begin
                            // perf is left holding the retired job's cycle count
                            state <= IDLE;
                        end
                    end else begin
                        elem_cnt <= elem_cnt + RegDataWidth'(inc);
                        perf     <= perf + 1'b1;
                        if (accept) begin
                            shadow       <= csr_reg_set_i;
                            shadow_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        csr_reg_ro_set_o = '0;
        csr_reg_ro_set_o[0 +: RegDataWidth]              = RegDataWidth'({shadow_valid, busy});
        csr_reg_ro_set_o[RegDataWidth +: RegDataWidth]   = perf;
        csr_reg_ro_set_o[2*RegDataWidth +: RegDataWidth] = jobs;
    end

    assign csr_reg_set_ready_o = !shadow_valid;
    assign csr_reg_active_o    = active;
    assign csr_alu_config_o    = active[AluCfgWidth-1:0];
    assign acc_ready_o         = busy;
    assign done_o              = done;

endmodule

// File: tb/tb_snax_alu_csr_ctrl.sv
// Directed bench for snax_alu_csr_ctrl: idle start, shadow queueing, clamped
// overshoot, back-to-back restart, zero-length jobs, idle lane noise and mid-job reset.
module tb_snax_alu_csr_ctrl;

    localparam int W = 32;

    logic         clk_i;
    logic         rst_ni;
    logic [127:0] csr_reg_set_i;
    logic         csr_reg_set_valid_i;
    logic         csr_reg_set_ready_o;
    logic [95:0]  csr_reg_ro_set_o;
    logic [127:0] csr_reg_active_o;
    logic [3:0]   acc_output_success_i;
    logic         acc_ready_o;
    logic [1:0]   csr_alu_config_o;
    logic         done_o;

    int checks   = 0;
    int failures = 0;

    snax_alu_csr_ctrl dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .csr_reg_set_i       (csr_reg_set_i),
        .csr_reg_set_valid_i (csr_reg_set_valid_i),
        .csr_reg_set_ready_o (csr_reg_set_ready_o),
        .csr_reg_ro_set_o    (csr_reg_ro_set_o),
        .csr_reg_active_o    (csr_reg_active_o),
        .acc_output_success_i(acc_output_success_i),
        .acc_ready_o         (acc_ready_o),
        .csr_alu_config_o    (csr_alu_config_o),
        .done_o              (done_o)
    );

    // clock / reset
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one clock; outputs are observed 1ns after the rising edge
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_cfg(input logic [31:0] cfg, input logic [31:0] len);
        csr_reg_set_i       = {32'h0, 32'h0, len, cfg};
        csr_reg_set_valid_i = 1'b1;
    endtask

    task automatic drop_cfg();
        csr_reg_set_valid_i = 1'b0;
        csr_reg_set_i       = '0;
    endtask

    function automatic logic [W-1:0] ro(input int idx);
        return csr_reg_ro_set_o[idx*W +: W];
    endfunction

    task automatic check_status(input string tag, input logic busy, input logic done,
                                input logic [W-1:0] perf, input logic [W-1:0] jobs);
        check({tag, "_busy"}, W'(acc_ready_o), W'(busy));
        check({tag, "_done"}, W'(done_o), W'(done));
        check({tag, "_perf"}, ro(1), perf);
        check({tag, "_jobs"}, ro(2), jobs);
    endtask

    initial begin
        rst_ni               = 1'b0;
        csr_reg_set_i        = '0;
        csr_reg_set_valid_i  = 1'b0;
        acc_output_success_i = '0;
        step();
        step();
        check("rst_ready", W'(csr_reg_set_ready_o), 32'd1);
        check("rst_ro0", ro(0), 32'd0);
        check_status("rst", 1'b0, 1'b0, 32'd0, 32'd0);
        check("rst_active", W'(csr_reg_active_o != '0), 32'd0);
        rst_ni = 1'b1;
        step();

        // job A: cfg=2 len=8, 2 lanes per cycle -> 4 busy cycles
        drive_cfg(32'd2, 32'd8);
        acc_output_success_i = 4'b0011;
        check("a_ready", W'(csr_reg_set_ready_o), 32'd1);
        step();
        drop_cfg();
        check("a_start_cfg", W'(csr_alu_config_o), 32'd2);
        check("a_start_ro0", ro(0), 32'd1);
        check_status("a_start", 1'b1, 1'b0, 32'd1, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_status($sformatf("a_run%0d", i), 1'b1, 1'b0, W'(i + 2), 32'd0);
        end
        step();
        check_status("a_fin", 1'b0, 1'b1, 32'd4, 32'd1);
        step();
        check("a_done_clr", W'(done_o), 32'd0);

        // job A2 cfg=1 len=4 one lane; job B cfg=3 len=2 queued in shadow
        drive_cfg(32'd1, 32'd4);
        acc_output_success_i = 4'b0100;
        step();
        drive_cfg(32'd3, 32'd2);
        step();
        drop_cfg();
        check("b_q_ready", W'(csr_reg_set_ready_o), 32'd0);
        check("b_q_ro0", ro(0), 32'd3);
        check("b_q_cfg", W'(csr_alu_config_o), 32'd1);
        step();
        step();
        check_status("b_q_run", 1'b1, 1'b0, 32'd4, 32'd1);
        step();
        check_status("b_promote", 1'b1, 1'b1, 32'd1, 32'd2);
        check("b_promote_cfg", W'(csr_alu_config_o), 32'd3);
        check("b_promote_ready", W'(csr_reg_set_ready_o), 32'd1);
        check("b_promote_ro0", ro(0), 32'd1);
        check("b_promote_len", csr_reg_active_o[W +: W], 32'd2);
        step();
        step();
        check_status("b_fin", 1'b0, 1'b1, 32'd2, 32'd3);

        // len=5 with all four lanes: overshoot clamps on the 2nd busy cycle
        drive_cfg(32'd0, 32'd5);
        acc_output_success_i = 4'b1111;
        step();
        drop_cfg();
        step();
        check_status("ov_run", 1'b1, 1'b0, 32'd2, 32'd3);
        step();
        check_status("ov_fin", 1'b0, 1'b1, 32'd2, 32'd4);

        // finish with empty shadow plus a same-cycle write: restart with no idle gap
        drive_cfg(32'd1, 32'd4);
        acc_output_success_i = 4'b1010;
        step();
        drop_cfg();
        step();
        drive_cfg(32'd2, 32'd3);
        step();
        drop_cfg();
        check_status("bb_restart", 1'b1, 1'b1, 32'd1, 32'd5);
        check("bb_cfg", W'(csr_alu_config_o), 32'd2);
        check("bb_ro0", ro(0), 32'd1);
        step();
        step();
        check_status("bb_fin", 1'b0, 1'b1, 32'd2, 32'd6);

        // zero-length job finishes on its first busy cycle
        drive_cfg(32'd3, 32'd0);
        acc_output_success_i = 4'b0000;
        step();
        drop_cfg();
        check_status("z_start", 1'b1, 1'b0, 32'd1, 32'd6);
        step();
        check_status("z_fin", 1'b0, 1'b1, 32'd1, 32'd7);

        // lane pulses while idle change nothing
        acc_output_success_i = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            check_status($sformatf("idle%0d", i), 1'b0, 1'b0, 32'd1, 32'd7);
        end
        check("idle_ro0", ro(0), 32'd0);

        // reset while busy with a full shadow
        acc_output_success_i = 4'b0000;
        drive_cfg(32'd2, 32'd100);
        step();
        drive_cfg(32'd1, 32'd7);
        step();
        drop_cfg();
        check("mr_ro0", ro(0), 32'd3);
        rst_ni = 1'b0;
        #1;
        check_status("mr_rst", 1'b0, 1'b0, 32'd0, 32'd0);
        check("mr_ro0_rst", ro(0), 32'd0);
        check("mr_cfg_rst", W'(csr_alu_config_o), 32'd0);
        check("mr_active_rst", W'(csr_reg_active_o != '0), 32'd0);
        step();
        rst_ni = 1'b1;
        step();
        check("mr_ready", W'(csr_reg_set_ready_o), 32'd1);
        check("mr_busy", W'(acc_ready_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
